uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte buffer and handshake sequencer directly upstream of uarttx in uart_top.
//  Host writes bytes at clk rate. The block queues them and presents them one
//  at a time on dintx/newd. It holds each byte until uarttx reports donetx.
//  This lets the host burst data without tracking the slow UART bit clock.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >=2
//  DATA_W  8   byte width; must match uarttx tx_data
//  ADDR_W  $clog2(DEPTH)  derived localparam, not overridable
// PORTS
//  clk       in   1         system clock; same clk that feeds uarttx
//  rst       in   1         async, active-low reset (0 = reset)
//  wr_en     in   1         host write strobe, one byte per clk
//  wr_data   in   DATA_W    host byte
//  clr_ovf   in   1         sync clear of overflow flag
//  full      out  1         count==DEPTH
//  empty     out  1         count==0
//  count     out  ADDR_W+1  stored entries, excluding the byte in flight
//  overflow  out  1         sticky; a write was attempted while full
//  busy      out  1         byte in flight (state==WAIT_DONE)
//  newd      out  1         to uarttx newd
//  dintx     out  DATA_W    to uarttx tx_data; stable while newd=1
//  donetx    in   1         from uarttx; high for >=1 uclk period at frame end
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//  - Pointers and count go to 0; overflow, newd and busy go to 0.
//  - dintx goes to 0, empty=1, full=0, state=IDLE, donetx_q=0.
//  - No write, pop or flag update occurs while rst=0.
//  Storage:
//  - mem[DEPTH], wr_ptr and rd_ptr are ADDR_W bits and wrap DEPTH-1 -> 0.
//  - full and empty derive from count, not from pointer compare.
//  Write:
//  - Occurs on any edge with wr_en=1 and full=0: mem[wr_ptr]<=wr_data, wr_ptr++.
//  - wr_en=1 with full=1: data dropped, overflow<=1, no pointer change.
//  - clr_ovf=1: overflow<=0. A dropped write on the same edge wins, so overflow stays 1.
//  Edge detect:
//  - donetx_q<=donetx every clk; done_rise = donetx & ~donetx_q.
//  FSM (2 states):
//  - IDLE: newd=0. If empty=0: pop, i.e. dintx<=mem[rd_ptr], rd_ptr++, newd<=1.
//    Then go to WAIT_DONE.
//  - WAIT_DONE: newd=1, dintx held. On done_rise: newd<=0, go to IDLE.
//    No pop on this edge.
//  - Pop is committed; the byte leaves the FIFO when newd rises.
//  Count:
//  - count = count + write - pop.
//  - Write and pop on the same edge: count unchanged.
//  - A write while full is never accepted, even if a pop happens on that edge.
//    full is evaluated before the edge.
//  Latency:
//  - Write at edge N into an empty FIFO, FSM idle: empty=0 after N.
//    Pop and newd=1 after edge N+1.
//  - done_rise seen at edge M: newd=0 after M. If not empty, next newd=1 after M+1.
//    Minimum 1 clk low gap.
//  - uarttx samples newd only on uclk edges. newd=1 held until done_rise, so no
//    byte is missed.
//  - Because newd drops within 1 clk of donetx rising, no double-send occurs.
//  Boundary cases:
//  - donetx already high on entry to WAIT_DONE (stale level): not an edge, ignored.
//  - donetx high across reset release: donetx_q resets to 0, so a spurious edge is
//    possible. Bench must release rst with donetx=0.
//  - Reset mid-WAIT_DONE: in-flight byte and all queued bytes discarded; newd drops
//    asynchronously.
//  - DEPTH entries plus one in flight gives DEPTH+1 bytes of total buffering.
// TESTING (DEPTH=4 for bench; donetx driven by real uarttx or a pulse model)
//  1. Write 0xA5 once -> newd=1 and dintx=0xA5 two clks after write.
//     count returns to 0; newd drops 1 clk after donetx rises.
//  2. Burst 0x11,0x22,0x33 on consecutive clks -> presented in order, one per
//     donetx pulse; empty=1 after third pop; tx line shows 3 frames.
//  3. Fill: hold busy, write 5 bytes -> full=1 after 4th stored.
//     5th dropped, overflow=1; clr_ovf -> overflow=0.
//  4. Full FIFO, wr_en on same edge as pop -> count stays 4 only if not full;
//     with full=1 the write is dropped and count goes 4->3.
//  5. Wrap: 10 bytes 0x00..0x09 written in chunks of 3 -> output order intact
//     across pointer wrap; no loss, no duplication.
//  6. Assert rst during WAIT_DONE with 2 queued -> newd=0 immediately, count=0,
//     empty=1; a post-reset write of 0x5A is the next byte sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue in front of uarttx. Bytes are buffered at clk rate and handed
// over one at a time on dintx/newd. Each byte is held until donetx rises.
//
// state     | meaning
// ----------|------------------------------------------------------------
// IDLE      | nothing in flight; pops the head byte when the queue is non-empty
// WAIT_DONE | byte in flight on dintx with newd=1; waits for a donetx rising edge
module uart_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_ovf,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              busy,
   output logic              newd,
   output logic [DATA_W-1:0] dintx,
   input  logic              donetx
);

   localparam int CNT_W = ADDR_W + 1;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_DONE = 1'b1
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              donetx_q;
   logic              done_rise;
   logic              do_write;
   logic              do_pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign done_rise = donetx & ~donetx_q;
   // full is the pre-edge value, so a pop on the same edge never frees room for the write
   assign do_write  = wr_en & ~full;
   assign do_pop    = (state == IDLE) & ~empty;

   always_ff @(posedge clk) begin
      if (rst && do_write)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         donetx_q <= 1'b0;
      end else begin
         donetx_q <= donetx;
         if (do_write)
            wr_ptr <= wr_ptr + 1'b1;
         case ({do_write, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // a dropped write beats a clear on the same edge
         if (wr_en && full)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         rd_ptr <= '0;
         newd   <= 1'b0;
         busy   <= 1'b0;
         dintx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (do_pop) begin
                  dintx  <= mem[rd_ptr];
                  rd_ptr <= rd_ptr + 1'b1;
                  newd   <= 1'b1;
                  busy   <= 1'b1;
                  state  <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (done_rise) begin
                  newd  <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed + randomized bench for uart_tx_fifo (DEPTH=4) against a queue-based model
// of the transmit path: stored bytes, one byte in flight, sticky overflow.
module tb_uart_tx_fifo;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              wr_en = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              clr_ovf = 1'b0;
   logic              donetx = 1'b0;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              busy;
   logic              newd;
   logic [DATA_W-1:0] dintx;

   uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
      .full(full), .empty(empty), .count(count), .overflow(overflow), .busy(busy),
      .newd(newd), .dintx(dintx), .donetx(donetx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   logic       m_inflight;
   logic [7:0] m_dintx;
   logic       m_ov;
   logic       m_done_prev;

   task automatic model_reset();
      q.delete();
      m_inflight  = 1'b0;
      m_dintx     = 8'h00;
      m_ov        = 1'b0;
      m_done_prev = 1'b0;
   endtask

   // one clock edge of the transmit path, from pre-edge state and inputs
   task automatic model_edge(input logic wr, input logic [7:0] d, input logic clr,
                             input logic dn);
      bit was_full;
      was_full = (q.size() == DEPTH);
      if (!m_inflight && q.size() != 0) begin
         m_dintx    = q.pop_front();
         m_inflight = 1'b1;
      end else if (m_inflight && dn && !m_done_prev) begin
         m_inflight = 1'b0;
      end
      if (wr && !was_full)
         q.push_back(d);
      if (wr && was_full)
         m_ov = 1'b1;
      else if (clr)
         m_ov = 1'b0;
      m_done_prev = dn;
   endtask

   function automatic logic [15:0] dut_vec();
      return {newd, busy, full, empty, overflow, count, dintx};
   endfunction

   function automatic logic [15:0] model_vec();
      return {m_inflight, m_inflight, q.size() == DEPTH, q.size() == 0, m_ov,
              3'(q.size()), m_dintx};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (newd,busy,full,empty,ovf,count,dintx)",
                tag, obs, exp);
      end
   endtask

   task automatic step(input logic wr, input logic [7:0] d, input logic clr,
                       input logic dn, input string tag);
      wr_en   = wr;
      wr_data = d;
      clr_ovf = clr;
      donetx  = dn;
      @(posedge clk);
      model_edge(wr, d, clr, dn);
      #1;
      chk(tag, dut_vec(), model_vec());
   endtask

   // one uarttx frame: random bit-time delay, then a 2-clk donetx pulse
   task automatic serve(input string tag);
      repeat ($urandom_range(1, 4)) step(1'b0, 8'h00, 1'b0, 1'b0, tag);
      step(1'b0, 8'h00, 1'b0, 1'b1, tag);
      step(1'b0, 8'h00, 1'b0, 1'b1, tag);
      step(1'b0, 8'h00, 1'b0, 1'b0, tag);
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while ((q.size() != 0 || m_inflight) && guard < 40) begin
         serve(tag);
         guard++;
      end
   endtask

   initial begin
      model_reset();
      #12;
      chk("reset", dut_vec(), model_vec());
      rst = 1'b1;

      // single byte latency
      step(1'b1, 8'hA5, 1'b0, 1'b0, "t1_wr");
      step(1'b0, 8'h00, 1'b0, 1'b0, "t1_pop");
      chk("t1_present", {7'd0, newd, dintx}, {7'd0, 1'b1, 8'hA5});
      serve("t1_done");

      // burst of three
      step(1'b1, 8'h11, 1'b0, 1'b0, "t2_wr");
      step(1'b1, 8'h22, 1'b0, 1'b0, "t2_wr");
      step(1'b1, 8'h33, 1'b0, 1'b0, "t2_wr");
      drain("t2_drain");
      chk("t2_empty", {15'd0, empty}, {15'd0, 1'b1});

      // fill while busy, overflow, clear
      step(1'b1, 8'($urandom), 1'b0, 1'b0, "t3_wr");
      step(1'b0, 8'h00, 1'b0, 1'b0, "t3_pop");
      for (int i = 0; i < 5; i++)
         step(1'b1, 8'($urandom), 1'b0, 1'b0, "t3_fill");
      chk("t3_full_ovf", {14'd0, full, overflow}, {14'd0, 1'b1, 1'b1});
      step(1'b1, 8'h99, 1'b1, 1'b0, "t3_drop_beats_clr");
      step(1'b0, 8'h00, 1'b1, 1'b0, "t3_clr");

      // write on the pop edge while full: dropped, count 4 -> 3
      step(1'b0, 8'h00, 1'b0, 1'b1, "t4_done");
      step(1'b1, 8'hEE, 1'b0, 1'b0, "t4_pop_wr_full");
      chk("t4_count", {13'd0, count}, {13'd0, 3'd3});
      step(1'b0, 8'h00, 1'b1, 1'b0, "t4_clr");
      drain("t4_drain");

      // pointer wrap, bytes 0..9 in chunks of three
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0, "t5_wr");
         if (i % 3 == 2 || i == 9)
            drain("t5_drain");
      end

      // stale donetx level when a byte launches
      step(1'b0, 8'h00, 1'b0, 1'b1, "stale_hi");
      step(1'b1, 8'h77, 1'b0, 1'b1, "stale_wr");
      step(1'b0, 8'h00, 1'b0, 1'b1, "stale_pop");
      step(1'b0, 8'h00, 1'b0, 1'b1, "stale_hold");
      chk("stale_newd", {15'd0, newd}, {15'd0, 1'b1});
      step(1'b0, 8'h00, 1'b0, 1'b0, "stale_lo");
      step(1'b0, 8'h00, 1'b0, 1'b1, "stale_rise");

      // reset in WAIT_DONE with two queued
      step(1'b1, 8'hC1, 1'b0, 1'b0, "t6_wr");
      step(1'b1, 8'hC2, 1'b0, 1'b0, "t6_wr");
      step(1'b1, 8'hC3, 1'b0, 1'b0, "t6_wr");
      step(1'b0, 8'h00, 1'b0, 1'b0, "t6_hold");
      wr_en  = 1'b0;
      donetx = 1'b0;
      rst    = 1'b0;
      #1;
      model_reset();
      chk("t6_async_rst", dut_vec(), model_vec());
      #2;
      rst = 1'b1;
      step(1'b1, 8'h5A, 1'b0, 1'b0, "t6_post_wr");
      step(1'b0, 8'h00, 1'b0, 1'b0, "t6_post_pop");
      chk("t6_next_byte", {7'd0, newd, dintx}, {7'd0, 1'b1, 8'h5A});
      drain("t6_drain");

      // randomized traffic
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 2) == 0), "rand");
      donetx = 1'b0;
      drain("rand_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
